fsm_loop_closer: RTL and testbench
==================================

# fsm_loop_closer

Sequential harness that closes the state feedback loop around a flattened two-level FSM benchmark netlist such as dk17. Those netlists carry present state as one-hot primary inputs and next state as one-hot primary outputs. This block registers the state and feeds it back. It accepts a stream of primary-input vectors over a valid/ready handshake and emits the registered primary outputs over a second handshake. It sits between the stimulus source and any power or activity monitor, so a combinational netlist can be exercised as the FSM it encodes.

## Interface
Parameters:
- NUM_PI, 2: primary inputs of the FSM.
- NUM_ST, 8: states (one-hot width).
- NUM_PO, 3: primary outputs of the FSM.
- RESET_ST, 0: index of the reset state.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_pi is valid.
- in_ready  out  1  block can accept in_pi this cycle.
- in_pi  in  NUM_PI  primary-input vector.
- comb_in  out  NUM_PI+NUM_ST  drives the netlist inputs: [NUM_PI-1:0]=in_pi, [NUM_PI+k]=state bit k.
- comb_out  in  NUM_ST+NUM_PO  netlist outputs: [NUM_ST-1:0]=next state one-hot, [NUM_ST+NUM_PO-1:NUM_ST]=PO.
- out_valid  out  1  out_po holds an unconsumed result.
- out_ready  in  1  consumer takes out_po.
- out_po  out  NUM_PO  registered primary outputs.
- state  out  NUM_ST  current one-hot state register.
- err  out  1  sticky: netlist returned a non-one-hot next state.
- err_pi  out  NUM_PI  in_pi captured at the error.
- steps  out  16  count of accepted transitions, saturating.

## Operation
- comb_in is combinational: {state, in_pi}. The netlist is purely combinational, so comb_out is sampled in the same cycle.
- in_ready = !err && (!out_valid || out_ready). Full throughput is one transition per cycle while the consumer keeps out_ready high.
- Accept means in_valid && in_ready at a rising edge. On accept, the block checks comb_out[NUM_ST-1:0] with a popcount:
  - Exactly one bit set: state <= next state, out_po <= PO field, out_valid <= 1, steps <= steps+1 (saturates at 16'hFFFF).
  - Zero or several bits set: state is held, err <= 1, err_pi <= in_pi, out_valid is not set by this accept, and steps is unchanged.
- Output register: out_valid clears on out_valid && out_ready unless a new accept happens in the same edge. Simultaneous pop and accept leaves out_valid = 1 with the new out_po.
- While err = 1:
  - in_ready = 0 and no further accepts.
  - A pending out_valid may still drain.
  - Only rst clears err.
- Input handshake rule: in_pi must stay stable while in_valid && !in_ready. The block does not buffer it.

## Timing
- Reset values (asynchronous):
  - state = one-hot with bit RESET_ST set.
  - out_valid = 0, out_po = 0, err = 0, err_pi = 0, steps = 0.
  - in_ready follows combinationally: 1 after reset.
- Latency: in_pi accepted at edge N gives out_po/out_valid visible after edge N, and state updated after edge N.
- Combinational paths: in_pi to comb_in; out_ready to in_ready; err to in_ready. There is no combinational path from comb_out to any output.
- Reset asserted mid-stream aborts immediately: a pending out_valid is dropped and the state returns to RESET_ST with no extra cycle.
- Deasserting rst during a clock edge is handled by the external reset synchronizer. The block expects a clean release.

## Test plan
- Reset then idle: rst pulse, in_valid = 0 for 5 cycles -> state = 8'b0000_0001, out_valid = 0, in_ready = 1, steps = 0.
- Single step with a behavioural netlist model returning next = 8'b0000_0100 and PO = 3'b101 for in_pi = 2'b10: one accept -> next cycle state = 8'b0000_0100, out_po = 3'b101, out_valid = 1, steps = 1.
- Backpressure: out_ready = 0 and in_valid = 1 continuously -> one accept, then in_ready = 0. Raise out_ready -> pop and new accept on the same edge, out_valid stays 1, steps increments once per edge thereafter.
- Illegal next state: the model returns 8'b0000_0000, then in a separate run 8'b0001_0010 -> err = 1, err_pi = offending in_pi, state unchanged, in_ready = 0. A pending output still drains. Further in_valid is ignored for 10 cycles.
- Saturation: 65 540 back-to-back accepts with out_ready = 1 -> steps = 16'hFFFF and it does not wrap.
- Async reset mid-run: assert rst between edges with out_valid = 1 and state != RESET_ST -> all outputs reach reset values before the next edge. Release rst -> accepts resume from RESET_ST.

Source files
------------

// File: rtl/fsm_loop_closer.sv
// -----------------------------------------------------------------------------
// fsm_loop_closer
// Closes the state feedback loop around a flattened, purely combinational
// two-level FSM netlist (e.g. dk17). The netlist sees {state, in_pi} on
// comb_in and returns {PO, next-state one-hot} on comb_out. This block holds
// the one-hot state register, accepts primary-input vectors over a valid/ready
// handshake and presents the registered primary outputs over a second
// valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_pi is valid
//   in_ready   block can accept in_pi this cycle (combinational)
//   in_pi      primary-input vector
//   comb_in    netlist inputs: [NUM_PI-1:0]=in_pi, [NUM_PI+k]=state bit k
//   comb_out   netlist outputs: [NUM_ST-1:0]=next state, upper NUM_PO bits=PO
//   out_valid  out_po holds an unconsumed result
//   out_ready  consumer takes out_po
//   out_po     registered primary outputs
//   state      current one-hot state register
//   err        sticky: netlist returned a non-one-hot next state
//   err_pi     in_pi captured at the error
//   steps      saturating count of legal accepted transitions
// -----------------------------------------------------------------------------
module fsm_loop_closer #(
    parameter int NUM_PI   = 2,
    parameter int NUM_ST   = 8,
    parameter int NUM_PO   = 3,
    parameter int RESET_ST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_PI-1:0]        in_pi,
    output logic [NUM_PI+NUM_ST-1:0] comb_in,
    input  logic [NUM_ST+NUM_PO-1:0] comb_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_PO-1:0]        out_po,
    output logic [NUM_ST-1:0]        state,
    output logic                     err,
    output logic [NUM_PI-1:0]        err_pi,
    output logic [15:0]              steps
);

    localparam int CNT_W = $clog2(NUM_ST + 1);
    localparam logic [NUM_ST-1:0] RESET_VEC = {{(NUM_ST-1){1'b0}}, 1'b1} << RESET_ST;

    // True when exactly one bit of the candidate next state is set.
    function automatic logic f_is_onehot(input logic [NUM_ST-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_ST; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return (cnt == CNT_W'(1));
    endfunction

    logic [NUM_ST-1:0] r_state;
    logic              r_out_valid;
    logic [NUM_PO-1:0] r_out_po;
    logic              r_err;
    logic [NUM_PI-1:0] r_err_pi;
    logic [15:0]       r_steps;

    logic              w_accept;
    logic              w_pop;
    logic [NUM_ST-1:0] w_next_st;
    logic [NUM_PO-1:0] w_next_po;
    logic              w_next_ok;

    assign w_next_st = comb_out[NUM_ST-1:0];
    assign w_next_po = comb_out[NUM_ST+NUM_PO-1:NUM_ST];
    assign w_next_ok = f_is_onehot(w_next_st);

    // Once err is set the block never accepts again; a pending result can still drain.
    assign in_ready = !r_err && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_pop    = r_out_valid && out_ready;

    assign comb_in   = {r_state, in_pi};
    assign state     = r_state;
    assign out_valid = r_out_valid;
    assign out_po    = r_out_po;
    assign err       = r_err;
    assign err_pi    = r_err_pi;
    assign steps     = r_steps;

    // State register, output register, error capture and transition counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_VEC;
            r_out_valid <= 1'b0;
            r_out_po    <= '0;
            r_err       <= 1'b0;
            r_err_pi    <= '0;
            r_steps     <= 16'd0;
        end else begin
            if (w_accept && w_next_ok) begin
                r_state     <= w_next_st;
                r_out_po    <= w_next_po;
                r_out_valid <= 1'b1;
                if (r_steps != 16'hFFFF) begin
                    r_steps <= r_steps + 16'd1;
                end else begin
                    r_steps <= r_steps;
                end
            end else if (w_accept) begin
                // Illegal next state: hold state, latch the offending input.
                r_err    <= 1'b1;
                r_err_pi <= in_pi;
                if (w_pop) begin
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_out_valid;
                end
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

endmodule

// File: tb/tb_fsm_loop_closer.sv
// -----------------------------------------------------------------------------
// tb_fsm_loop_closer
// Self-checking bench. A behavioural netlist maps (state index, pi) to a next
// state index and PO value; it can be forced to return an illegal next-state
// vector. The reference model tracks the FSM as an integer state index plus
// handshake and counter bookkeeping, and each test task compares DUT outputs
// against it or against fixed expected constants.
// -----------------------------------------------------------------------------
module tb_fsm_loop_closer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_pi;
    logic [9:0]  comb_in;
    logic [10:0] comb_out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_po;
    logic [7:0]  state;
    logic        err;
    logic [1:0]  err_pi;
    logic [15:0] steps;

    int bad_sel;
    int n_checks;
    int n_pass;

    // reference model
    int         m_state;
    logic       m_valid;
    logic [2:0] m_po;
    logic       m_err;
    logic [1:0] m_err_pi;
    int         m_steps;
    logic       last_acc;

    fsm_loop_closer #(.NUM_PI(2), .NUM_ST(8), .NUM_PO(3), .RESET_ST(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pi(in_pi),
        .comb_in(comb_in), .comb_out(comb_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_po(out_po),
        .state(state), .err(err), .err_pi(err_pi), .steps(steps)
    );

    always #5 clk = ~clk;

    function automatic int net_next(input int s, input int pi);
        return (s + pi) % 8;
    endfunction

    function automatic int net_po(input int s, input int pi);
        return (s + 2 * pi + 1) % 8;
    endfunction

    // behavioural netlist
    always_comb begin
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            if (comb_in[2 + k]) s = k;
        end
        comb_out = {3'(net_po(s, int'(comb_in[1:0]))), 8'(1 << net_next(s, int'(comb_in[1:0])))};
        if (bad_sel == 1) comb_out[7:0] = 8'h00;
        else if (bad_sel == 2) comb_out[7:0] = 8'h12;
    end

    task automatic model_reset();
        m_state = 0; m_valid = 1'b0; m_po = 3'd0; m_err = 1'b0;
        m_err_pi = 2'd0; m_steps = 0; last_acc = 1'b0;
    endtask

    // one clock: predict the edge from the model, advance, land at edge+1
    task automatic do_cycle();
        logic rdy, acc, pop;
        int   pi;
        rdy = !m_err && (!m_valid || out_ready);
        acc = in_valid && rdy;
        pop = m_valid && out_ready;
        pi  = int'(in_pi);
        @(posedge clk); #1;
        if (acc && bad_sel == 0) begin
            m_po = 3'(net_po(m_state, pi));
            m_state = net_next(m_state, pi);
            m_valid = 1'b1;
            if (m_steps < 65535) m_steps++;
        end else if (acc) begin
            m_err = 1'b1;
            m_err_pi = 2'(pi);
            if (pop) m_valid = 1'b0;
        end else if (pop) begin
            m_valid = 1'b0;
        end
        last_acc = acc;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pi = 2'd0; bad_sel = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) do_cycle();
        n_checks++; if (state !== 8'b0000_0001) $display("FAIL reset_state got %b exp %b", state, 8'b0000_0001); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (steps !== 16'd0) $display("FAIL reset_steps got %0d exp 0", steps); else n_pass++;
        n_checks++; if (err !== 1'b0 || err_pi !== 2'd0 || out_po !== 3'd0)
            $display("FAIL reset_misc got err=%b err_pi=%b po=%b exp 0/00/000", err, err_pi, out_po); else n_pass++;
    endtask

    task automatic test_single_step();
        in_pi = 2'b10; in_valid = 1'b1; out_ready = 1'b0;
        do_cycle();
        in_valid = 1'b0;
        n_checks++; if (state !== 8'b0000_0100) $display("FAIL step_state got %b exp %b", state, 8'b0000_0100); else n_pass++;
        n_checks++; if (out_po !== 3'b101) $display("FAIL step_po got %b exp 101", out_po); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL step_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (steps !== 16'd1) $display("FAIL step_steps got %0d exp 1", steps); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL step_in_ready got %b exp 0", in_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_pi = 2'd1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            n_checks++; if (in_ready !== 1'b0 || steps !== 16'd1 || out_valid !== 1'b1)
                $display("FAIL bp_stall got rdy=%b steps=%0d valid=%b exp 0/1/1", in_ready, steps, out_valid); else n_pass++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            n_checks++; if (out_valid !== 1'b1 || steps !== 16'(2 + i))
                $display("FAIL bp_flow got valid=%b steps=%0d exp 1/%0d", out_valid, steps, 2 + i); else n_pass++;
            n_checks++; if (state !== 8'(1 << m_state) || out_po !== m_po)
                $display("FAIL bp_data got state=%b po=%b exp %b/%b", state, out_po, 8'(1 << m_state), m_po); else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_pi = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            do_cycle();
            n_checks++; if (state !== 8'(1 << m_state) || out_valid !== m_valid || steps !== 16'(m_steps))
                $display("FAIL rand_core cyc %0d got st=%b v=%b n=%0d exp %b/%b/%0d", i, state, out_valid, steps, 8'(1 << m_state), m_valid, m_steps); else n_pass++;
            n_checks++; if (out_po !== m_po || in_ready !== (!m_err && (!m_valid || out_ready)))
                $display("FAIL rand_out cyc %0d got po=%b rdy=%b exp po=%b", i, out_po, in_ready, m_po); else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal(input int sel);
        int         held;
        logic [1:0] bad_pi;
        apply_reset();
        in_valid = 1'b1; in_pi = 2'd3; out_ready = 1'b0;
        do_cycle();                       // legal step, result left pending
        held = m_state;
        bad_pi = 2'($urandom_range(0, 3));
        in_pi = bad_pi; out_ready = 1'b1; bad_sel = sel;
        do_cycle();                       // illegal accept with simultaneous drain
        bad_sel = 0;
        n_checks++; if (err !== 1'b1 || err_pi !== bad_pi)
            $display("FAIL illegal%0d_err got err=%b err_pi=%b exp 1/%b", sel, err, err_pi, bad_pi); else n_pass++;
        n_checks++; if (state !== 8'(1 << held) || in_ready !== 1'b0)
            $display("FAIL illegal%0d_hold got st=%b rdy=%b exp %b/0", sel, state, in_ready, 8'(1 << held)); else n_pass++;
        n_checks++; if (out_valid !== 1'b0 || steps !== 16'd1)
            $display("FAIL illegal%0d_drain got valid=%b steps=%0d exp 0/1", sel, out_valid, steps); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            do_cycle();
            n_checks++; if (err !== 1'b1 || state !== 8'(1 << held) || steps !== 16'd1 || in_ready !== 1'b0 || err_pi !== bad_pi)
                $display("FAIL illegal%0d_ignore cyc %0d got err=%b st=%b n=%0d rdy=%b", sel, i, err, state, steps, in_ready); else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            in_pi = 2'($urandom_range(0, 3));
            do_cycle();
            if (i == 65533) begin
                n_checks++; if (steps !== 16'hFFFE) $display("FAIL sat_pre got %h exp fffe", steps); else n_pass++;
            end
            if (i == 65534) begin
                n_checks++; if (steps !== 16'hFFFF) $display("FAIL sat_hit got %h exp ffff", steps); else n_pass++;
            end
        end
        n_checks++; if (steps !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", steps); else n_pass++;
        n_checks++; if (state !== 8'(1 << m_state) || out_valid !== 1'b1)
            $display("FAIL sat_state got st=%b v=%b exp %b/1", state, out_valid, 8'(1 << m_state)); else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_valid = 1'b1; in_pi = 2'd1; out_ready = 1'b0;
        do_cycle();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || state !== 8'b0000_0010)
            $display("FAIL arst_pre got v=%b st=%b exp 1/00000010", out_valid, state); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (state !== 8'b0000_0001 || out_valid !== 1'b0 || steps !== 16'd0 || out_po !== 3'd0 || err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL arst_now got st=%b v=%b n=%0d po=%b err=%b rdy=%b", state, out_valid, steps, out_po, err, in_ready); else n_pass++;
        #2 rst = 1'b0;
        model_reset();
        in_valid = 1'b1; in_pi = 2'b10; out_ready = 1'b1;
        do_cycle();
        in_valid = 1'b0;
        n_checks++; if (state !== 8'b0000_0100 || out_po !== 3'b101 || steps !== 16'd1 || out_valid !== 1'b1)
            $display("FAIL arst_resume got st=%b po=%b n=%0d v=%b exp 00000100/101/1/1", state, out_po, steps, out_valid); else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; bad_sel = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pi = 2'd0;
        model_reset();
        test_reset();
        test_single_step();
        test_backpressure();
        test_random();
        test_illegal(1);
        test_illegal(2);
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
